// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares the unified Segre memory port between the
// instruction-fetch and data ports. One access in flight at a time; the
// memory strobes and fields are registered and held until mem_ready_i.
// Simultaneous requests are granted round-robin.
module segre_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rsn_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,

  input  logic              dm_req_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [1:0]        dm_type_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_data_type_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_e;

  state_e            state_q;
  logic              lastDm_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWrData_q;
  logic              memRd_q;
  logic              memWr_q;
  logic [1:0]        memType_q;

  logic              grantIf_d;
  logic              grantDm_d;
  logic              ifValid;
  logic              dmValid;

  // Round-robin grant: on contention the port that was not served last wins.
  always_comb begin
    grantDm_d = dm_req_i & (~if_req_i | ~lastDm_q);
    grantIf_d = if_req_i & ~grantDm_d;
  end

  // Arbiter FSM: latch one request in IDLE, hold the strobes until ready.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      lastDm_q    <= 1'b0;
      memAddr_q   <= '0;
      memWrData_q <= '0;
      memRd_q     <= 1'b0;
      memWr_q     <= 1'b0;
      memType_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantDm_d) begin
            state_q     <= DM_BUSY;
            lastDm_q    <= 1'b1;
            memAddr_q   <= dm_addr_i;
            memWrData_q <= dm_wr_i ? dm_wdata_i : '0;
            memRd_q     <= ~dm_wr_i;
            memWr_q     <= dm_wr_i;
            memType_q   <= dm_type_i;
          end else if (grantIf_d) begin
            state_q     <= IF_BUSY;
            lastDm_q    <= 1'b0;
            memAddr_q   <= if_addr_i;
            memWrData_q <= '0;
            memRd_q     <= 1'b1;
            memWr_q     <= 1'b0;
            memType_q   <= 2'd2;
          end
        end
        IF_BUSY, DM_BUSY: begin
          if (mem_ready_i) begin
            state_q     <= IDLE;
            memAddr_q   <= '0;
            memWrData_q <= '0;
            memRd_q     <= 1'b0;
            memWr_q     <= 1'b0;
            memType_q   <= 2'd0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Completion is signalled in the ready cycle itself, only to the owner.
  always_comb begin
    ifValid    = (state_q == IF_BUSY) & mem_ready_i;
    dmValid    = (state_q == DM_BUSY) & mem_ready_i;
    if_valid_o = ifValid;
    dm_valid_o = dmValid;
    if_rdata_o = ifValid ? mem_rd_data_i : '0;
    dm_rdata_o = (dmValid & memRd_q) ? mem_rd_data_i : '0;
  end

  assign mem_addr_o      = memAddr_q;
  assign mem_wr_data_o   = memWrData_q;
  assign mem_rd_o        = memRd_q;
  assign mem_wr_o        = memWr_q;
  assign mem_data_type_o = memType_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Testbench for segre_mem_arbiter: two requester drivers and a memory model
// generate traffic; a negedge monitor checks every cycle against a
// transaction-level model of the arbitration rules and per-port queues.
module tb_segre_mem_arbiter;

  logic        clk_i;
  logic        rsn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        dm_req_i;
  logic        dm_wr_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [1:0]  dm_type_i;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic [1:0]  mem_data_type_o;
  logic [31:0] mem_rd_data_i;
  logic        mem_ready_i;

  segre_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_type_i(dm_type_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_data_type_o(mem_data_type_o),
    .mem_rd_data_i(mem_rd_data_i), .mem_ready_i(mem_ready_i)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  typ;
  } txn_t;

  // Scoreboard: one queue of expected transactions per port.
  txn_t ifQ[$];
  txn_t dmQ[$];

  logic [31:0] memArr [logic [31:0]];

  int checks   = 0;
  int failures = 0;

  // Owner encoding for the model: 0 none, 1 fetch, 2 data.
  int busyOwner  = 0;
  int lastServed = 1;

  int ifMode = 0;
  int dmMode = 0;
  logic ifDirReq = 0;
  logic dmDirReq = 0;
  logic ifDirScramble = 0;
  txn_t ifDirTxn;
  txn_t dmDirTxn;
  int ifDoneCount = 0;
  int dmDoneCount = 0;
  logic ifPending = 0;
  logic dmPending = 0;

  int memFixedWait = -1;
  logic memStall = 0;
  int memLatCur = 0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired, got no completion, expected one at %0t", name, $time);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(mem_wr_data_o), 64'd0);
    checkOutput({tag, "_ctrl"}, 64'({mem_rd_o, mem_wr_o, mem_data_type_o, if_valid_o, dm_valid_o}), 64'd0);
    checkOutput({tag, "_if_rdata"}, 64'(if_rdata_o), 64'd0);
    checkOutput({tag, "_dm_rdata"}, 64'(dm_rdata_o), 64'd0);
  endtask

  // Hands one directed transaction to a driver and waits for its completion.
  task automatic applyStimulus(input int port, input txn_t t, input logic scramble);
    int startCount;
    bit done;
    @(posedge clk_i);
    #1;
    if (port == 1) begin
      startCount = ifDoneCount;
      ifDirTxn = t;
      ifDirScramble = scramble;
      ifDirReq = 1'b1;
    end else begin
      startCount = dmDoneCount;
      dmDirTxn = t;
      dmDirReq = 1'b1;
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk_i);
      #2;
      done = (port == 1) ? (ifDoneCount != startCount) : (dmDoneCount != startCount);
    end
    if (!done) reportTimeout("directed_completion");
  endtask

  task automatic drainDrivers();
    ifMode = 0;
    dmMode = 0;
    for (int i = 0; i < 60 && (ifPending || dmPending); i++) @(posedge clk_i);
    if (ifPending || dmPending) reportTimeout("drain");
  endtask

  // Fetch requester: holds its request until valid, then drops or replaces it.
  initial begin
    logic seen;
    txn_t t;
    if_req_i = 1'b0;
    if_addr_i = '0;
    forever begin
      @(negedge clk_i);
      seen = if_valid_o;
      @(posedge clk_i);
      #1;
      if (!rsn_i) begin
        ifPending = 0;
        if_req_i = 1'b0;
        ifQ.delete();
        continue;
      end
      if (ifPending && seen) begin
        ifPending = 0;
        if_req_i = 1'b0;
        ifDoneCount++;
      end else if (ifPending && busyOwner == 1 && mem_rd_o) begin
        if (ifDirScramble) if_addr_i = 32'h200;
        else if (ifMode != 0 && $urandom_range(0, 3) == 0) if_addr_i = $urandom;
      end
      if (!ifPending) begin
        if (ifDirReq) begin
          t = ifDirTxn;
          ifDirReq = 1'b0;
        end else if (ifMode == 2 || (ifMode == 1 && $urandom_range(0, 2) == 0)) begin
          ifDirScramble = 1'b0;
          t.addr = $urandom;
        end else begin
          continue;
        end
        t.wr = 1'b0;
        t.wdata = '0;
        t.typ = 2'd2;
        if_addr_i = t.addr;
        if_req_i = 1'b1;
        ifPending = 1;
        ifQ.push_back(t);
      end
    end
  end

  // Data requester: same protocol; scrambles its fields while being served.
  initial begin
    logic seen;
    txn_t t;
    dm_req_i = 1'b0;
    dm_wr_i = 1'b0;
    dm_addr_i = '0;
    dm_wdata_i = '0;
    dm_type_i = '0;
    forever begin
      @(negedge clk_i);
      seen = dm_valid_o;
      @(posedge clk_i);
      #1;
      if (!rsn_i) begin
        dmPending = 0;
        dm_req_i = 1'b0;
        dmQ.delete();
        continue;
      end
      if (dmPending && seen) begin
        dmPending = 0;
        dm_req_i = 1'b0;
        dmDoneCount++;
      end else if (dmPending && busyOwner == 2 && (mem_rd_o || mem_wr_o) && dmMode != 0
                   && $urandom_range(0, 3) == 0) begin
        dm_addr_i = $urandom;
        dm_wdata_i = $urandom;
        dm_wr_i = 1'($urandom_range(0, 1));
        dm_type_i = 2'($urandom_range(0, 2));
      end
      if (!dmPending) begin
        if (dmDirReq) begin
          t = dmDirTxn;
          dmDirReq = 1'b0;
        end else if (dmMode == 2 || (dmMode == 1 && $urandom_range(0, 2) == 0)) begin
          t.wr = 1'($urandom_range(0, 1));
          t.addr = $urandom;
          t.wdata = $urandom;
          t.typ = 2'($urandom_range(0, 2));
        end else begin
          continue;
        end
        dm_wr_i = t.wr;
        dm_addr_i = t.addr;
        dm_wdata_i = t.wdata;
        dm_type_i = t.typ;
        dm_req_i = 1'b1;
        dmPending = 1;
        dmQ.push_back(t);
      end
    end
  end

  // Memory model: picks a wait count per access, returns data for reads.
  initial begin
    logic prevStrobe;
    logic prevReady;
    logic strobe;
    int cnt;
    prevStrobe = 0;
    prevReady = 0;
    cnt = 0;
    mem_ready_i = 1'b0;
    mem_rd_data_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!rsn_i) begin
        prevStrobe = 0;
        mem_ready_i = 1'b0;
        continue;
      end
      strobe = mem_rd_o | mem_wr_o;
      if (strobe) begin
        if (!prevStrobe || prevReady) begin
          memLatCur = (memFixedWait >= 0) ? memFixedWait : int'($urandom_range(0, 3));
          cnt = 0;
        end
        mem_ready_i = !memStall && (cnt == memLatCur);
        cnt++;
        mem_rd_data_i = mem_rd_o ? memRead(mem_addr_o) : $urandom;
      end else begin
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rd_data_i = $urandom;
      end
      prevStrobe = strobe;
      prevReady = mem_ready_i;
    end
  end

  // Monitor: derives the expected grant and completion from the model each cycle.
  initial begin
    logic strobe, prevStrobe, prevValid, prevIfReq, prevDmReq;
    logic expIfV, expDmV;
    logic [31:0] snapAddr, snapWdata;
    logic [3:0] snapCtrl;
    int expOwner, busyCycles;
    txn_t t;
    prevStrobe = 0; prevValid = 0; prevIfReq = 0; prevDmReq = 0; busyCycles = 0;
    snapAddr = '0; snapWdata = '0; snapCtrl = '0;
    forever begin
      @(negedge clk_i);
      if (!rsn_i) begin
        lastServed = 1;
        busyOwner = 0;
        prevStrobe = 0; prevValid = 0; prevIfReq = 0; prevDmReq = 0;
        continue;
      end
      strobe = mem_rd_o | mem_wr_o;
      checkOutput("valid_excl", 64'(if_valid_o & dm_valid_o), 64'd0);
      if (!prevStrobe) checkOutput("grant_latency", 64'(strobe), 64'(prevIfReq | prevDmReq));
      if (prevValid) checkOutput("strobe_gap", 64'(strobe), 64'd0);
      if (!strobe) begin
        checkOutput("idle_addr", 64'(mem_addr_o), 64'd0);
        checkOutput("idle_wdata", 64'(mem_wr_data_o), 64'd0);
        checkOutput("idle_ctrl", 64'({mem_data_type_o, if_valid_o, dm_valid_o}), 64'd0);
      end else begin
        checkOutput("strobe_excl", 64'(mem_rd_o & mem_wr_o), 64'd0);
        if (!prevStrobe || prevValid) begin
          if (prevIfReq && prevDmReq) expOwner = (lastServed == 1) ? 2 : 1;
          else if (prevDmReq) expOwner = 2;
          else if (prevIfReq) expOwner = 1;
          else expOwner = 0;
          if (expOwner == 1 && ifQ.size() > 0) t = ifQ[0];
          else if (expOwner == 2 && dmQ.size() > 0) t = dmQ[0];
          else expOwner = 0;
          if (expOwner != 0) begin
            checkOutput("grant_addr", 64'(mem_addr_o), 64'(t.addr));
            checkOutput("grant_ctrl", 64'({mem_rd_o, mem_wr_o, mem_data_type_o}), 64'({~t.wr, t.wr, t.typ}));
            checkOutput("grant_wdata", 64'(mem_wr_data_o), 64'(t.wr ? t.wdata : 32'h0));
            lastServed = expOwner;
          end
          busyOwner = expOwner;
          busyCycles = 0;
          snapAddr = mem_addr_o;
          snapWdata = mem_wr_data_o;
          snapCtrl = {mem_rd_o, mem_wr_o, mem_data_type_o};
        end else begin
          checkOutput("hold_addr", 64'(mem_addr_o), 64'(snapAddr));
          checkOutput("hold_wdata", 64'(mem_wr_data_o), 64'(snapWdata));
          checkOutput("hold_ctrl", 64'({mem_rd_o, mem_wr_o, mem_data_type_o}), 64'(snapCtrl));
        end
        busyCycles++;
      end
      expIfV = strobe && mem_ready_i && busyOwner == 1;
      expDmV = strobe && mem_ready_i && busyOwner == 2;
      checkOutput("if_valid", 64'(if_valid_o), 64'(expIfV));
      checkOutput("dm_valid", 64'(dm_valid_o), 64'(expDmV));
      if (if_valid_o && expIfV && ifQ.size() > 0) begin
        t = ifQ.pop_front();
        checkOutput("if_rdata", 64'(if_rdata_o), 64'(memRead(t.addr)));
        checkOutput("if_latency", 64'(busyCycles), 64'(memLatCur + 1));
      end else begin
        checkOutput("if_rdata_quiet", 64'(if_rdata_o), 64'd0);
      end
      if (dm_valid_o && expDmV && dmQ.size() > 0) begin
        t = dmQ.pop_front();
        checkOutput("dm_rdata", 64'(dm_rdata_o), 64'(t.wr ? 32'h0 : memRead(t.addr)));
        checkOutput("dm_latency", 64'(busyCycles), 64'(memLatCur + 1));
      end else begin
        checkOutput("dm_rdata_quiet", 64'(dm_rdata_o), 64'd0);
      end
      if (expIfV || expDmV) busyOwner = 0;
      prevValid = if_valid_o | dm_valid_o;
      prevStrobe = strobe;
      prevIfReq = if_req_i;
      prevDmReq = dm_req_i;
    end
  end

  // Test sequence: reset, directed cases, contention, random traffic, abort.
  initial begin
    txn_t t;
    int abortValids;
    rsn_i = 1'b0;
    memArr[32'h100] = 32'hDEAD_BEEF;
    memArr[32'h40]  = 32'h0000_BEEF;

    repeat (3) @(posedge clk_i);
    #1;
    checkResetOutputs("reset");
    @(posedge clk_i);
    #4;
    rsn_i = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("[TB] directed accesses");
    memFixedWait = 1;
    t.wr = 1'b0; t.addr = 32'h100; t.wdata = '0; t.typ = 2'd2;
    applyStimulus(1, t, 1'b0);
    memFixedWait = 3;
    t.wr = 1'b1; t.addr = 32'h203; t.wdata = 32'hAB; t.typ = 2'd0;
    applyStimulus(2, t, 1'b0);
    t.wr = 1'b0; t.addr = 32'h100; t.wdata = '0; t.typ = 2'd2;
    applyStimulus(1, t, 1'b1);
    memFixedWait = 0;
    t.wr = 1'b0; t.addr = 32'h40; t.wdata = '0; t.typ = 2'd1;
    applyStimulus(2, t, 1'b0);

    $display("[TB] contention from reset");
    @(posedge clk_i);
    #3;
    rsn_i = 1'b0;
    ifMode = 2;
    dmMode = 2;
    @(posedge clk_i);
    #4;
    rsn_i = 1'b1;
    repeat (40) @(posedge clk_i);
    drainDrivers();

    $display("[TB] random traffic");
    memFixedWait = -1;
    ifMode = 1;
    dmMode = 1;
    repeat (800) @(posedge clk_i);
    drainDrivers();

    $display("[TB] reset during pending store");
    memStall = 1'b1;
    t.wr = 1'b1; t.addr = 32'h300; t.wdata = 32'h1234_5678; t.typ = 2'd2;
    @(posedge clk_i);
    #1;
    dmDirTxn = t;
    dmDirReq = 1'b1;
    for (int i = 0; i < 10 && !mem_wr_o; i++) @(negedge clk_i);
    repeat (2) @(posedge clk_i);
    #3;
    checkOutput("abort_store_pending", 64'(mem_wr_o), 64'd1);
    rsn_i = 1'b0;
    #1;
    checkResetOutputs("abort");
    memStall = 1'b0;
    @(posedge clk_i);
    #4;
    rsn_i = 1'b1;
    abortValids = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (dm_valid_o) abortValids++;
    end
    checkOutput("abort_no_valid", 64'(abortValids), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Two-port arbiter that shares the single unified memory interface of the Segre SoC between the core's instruction-fetch port and its data (load/store) port. It sits between the core pipeline and the memory model. It latches one request at a time, drives the memory strobes until the memory signals ready, and routes the completion back to the requester. Contention is resolved round-robin, so neither port starves.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk_i  in  1  clock; one clock for the whole block
- rsn_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_valid_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word; mem_rd_data_i when if_valid_o, else 0
- if_valid_o  out  1  fetch completes this cycle
- dm_req_i  in  1  data request; held with all dm_* fields stable until dm_valid_o
- dm_wr_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_type_i  in  2  access size: 0 = byte, 1 = half, 2 = word
- dm_rdata_o  out  DATA_W  load data; mem_rd_data_i when dm_valid_o and load, else 0
- dm_valid_o  out  1  data access completes this cycle (loads and stores)
- mem_addr_o  out  ADDR_W  registered address to memory
- mem_wr_data_o  out  DATA_W  registered store data (0 for reads)
- mem_rd_o  out  1  registered read strobe
- mem_wr_o  out  1  registered write strobe
- mem_data_type_o  out  2  registered access size; fetch always 2 (word)
- mem_rd_data_i  in  DATA_W  read data from memory
- mem_ready_i  in  1  memory completes current access; ignored when no strobe is high

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY. Register last_served ∈ {IF, DM}.
- IDLE, no request: stay; all mem outputs 0.
- IDLE, only if_req_i: latch {if_addr_i, word, read} into mem registers; go to IF_BUSY; last_served <= IF.
- IDLE, only dm_req_i: latch {dm_addr_i, dm_type_i, dm_wdata_i (or 0 if load), rd = ~dm_wr_i, wr = dm_wr_i}; go to DM_BUSY; last_served <= DM.
- IDLE, both requests: grant the port not equal to last_served (round-robin).
- IF_BUSY/DM_BUSY: hold all mem registers constant. While mem_ready_i = 0, stay.
- On mem_ready_i = 1: assert the owner's valid combinationally in the same cycle, pass rdata as defined, clear mem_rd_o/mem_wr_o, and go to IDLE next edge.
- Exactly one of mem_rd_o/mem_wr_o is high in a BUSY state; both are 0 in IDLE.
- Requester changes in a BUSY state are ignored; only the latched copy is used. A requester must drop or replace its request in the cycle after its valid.
- if_valid_o and dm_valid_o are never high together. The non-owner's valid and rdata are 0.
- No address alignment checks; size and address pass through unchanged.

## Timing
- Reset (rsn_i low, any time, including mid-transaction): state = IDLE, last_served = IF, and every output is 0 (mem_addr_o, mem_wr_data_o, mem_rd_o, mem_wr_o, mem_data_type_o, both valids, both rdatas). An aborted transaction is not completed after reset release.
- A request seen in IDLE at edge t produces strobes at cycle t+1.
- With mem_ready_i high in cycle t+1, valid is high in cycle t+1 and the FSM is in IDLE at t+2. Minimum 2 cycles per access; one access in flight.
- A new request sampled in IDLE at t+2 produces strobes at t+3, giving a 1-cycle strobe gap between back-to-back accesses.
- The first contention after reset grants DM, because last_served resets to IF.

## Test plan
- Reset values: hold rsn_i low, then release → all outputs 0 and state IDLE. Assert rsn_i low during DM_BUSY (store pending) → mem_wr_o drops to 0 immediately, and no dm_valid_o ever fires for that store.
- Single fetch: if_req_i = 1 with addr 0x100, memory ready 1 cycle after strobe, returns 0xDEADBEEF → mem_rd_o = 1, mem_data_type_o = 2, mem_addr_o = 0x100 at t+1; if_valid_o = 1 with if_rdata_o = 0xDEADBEEF at t+2; dm_valid_o stays 0.
- Store byte with wait states: dm_wr_i = 1, addr 0x203, wdata 0xAB, type 0, mem_ready_i delayed 3 cycles → mem_wr_o and all fields held constant for 4 cycles; dm_valid_o pulses one cycle; dm_rdata_o = 0.
- Contention round-robin: both requests held continuously from reset, memory always ready → grant order DM, IF, DM, IF…; each valid goes to the correct port, and no two consecutive grants go to the same port.
- Input change while busy: during IF_BUSY, change if_addr_i from 0x100 to 0x200 → mem_addr_o stays 0x100 until completion.
- Load half: dm_req_i, load, type 1, addr 0x40, memory returns 0x0000BEEF → mem_rd_o = 1, mem_wr_data_o = 0, dm_rdata_o = 0x0000BEEF in the ready cycle, if_rdata_o = 0.
